// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet-style frame receiver.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DST,
    SRC,
    LEN,
    PAYLOAD,
    CHK,
    DROP
  } state_t;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam int          ADDR_BYTES = 6;

endpackage

// File: rtl/rx_buffer.sv
// Circular payload buffer with a speculative write pointer that is either
// committed (made visible to the reader) or rolled back at end of frame.
module rx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   rd_count
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes a full buffer from an empty one.
  logic [AW:0] wr_ptr;
  logic [AW:0] cmt_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        rd_fire;

  assign rd_count = cmt_ptr - rd_ptr;
  assign rd_fire  = rd_en && (rd_count != '0);
  assign rd_data  = (rd_count != '0) ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rollback)
        wr_ptr <= cmt_ptr;
      else if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (commit)
        cmt_ptr <= wr_ptr;
      if (rd_fire)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are meaningful, and rd_data is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/eth_frame_rx.sv
// Frame receiver: preamble/SFD hunt, address filter, length and checksum
// handling; payload is staged in rx_buffer and only committed on a good frame.
module eth_frame_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR  = 48'h4A6F8A7FAA8F,
  parameter int          BUF_DEPTH = 16,
  parameter int          MIN_PRE   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         promisc,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data,
  output logic [$clog2(BUF_DEPTH):0]   rd_count,
  output logic                         frame_ok,
  output logic                         frame_err,
  output logic [7:0]                   last_len,
  output logic [7:0]                   drop_cnt
);

  state_t      state, state_d;
  logic [7:0]  pre_cnt;
  logic [7:0]  idx;
  logic [7:0]  len;
  logic [7:0]  sum;
  logic [39:0] dst_sr;
  logic [47:0] dst_full;
  logic [9:0]  free_space;
  logic        addr_match;

  logic pre_inc, pre_clr, idx_inc, idx_clr, len_ld, sum_clr;
  logic buf_wr, buf_commit, buf_rollback, drop_inc, ok_d, err_d;

  // The sixth destination byte is compared combinationally as it arrives.
  assign dst_full   = {dst_sr, rx_data};
  assign addr_match = (dst_full == MAC_ADDR) || (dst_full == BCAST_MAC) || promisc;
  assign free_space = 10'(BUF_DEPTH) - 10'(rd_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    pre_inc      = 1'b0;
    pre_clr      = 1'b0;
    idx_inc      = 1'b0;
    idx_clr      = 1'b0;
    len_ld       = 1'b0;
    sum_clr      = 1'b0;
    buf_wr       = 1'b0;
    buf_commit   = 1'b0;
    buf_rollback = 1'b0;
    drop_inc     = 1'b0;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == PRE_BYTE) begin
            pre_inc = 1'b1;
          end else begin
            pre_clr = 1'b1;
            if (rx_data == SFD_BYTE && pre_cnt >= 8'(MIN_PRE)) begin
              state_d = DST;
              idx_clr = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!rx_valid) state_d = IDLE;
      end
      default: begin
        if (!rx_valid) begin
          // A gap inside a frame is a truncation.
          buf_rollback = 1'b1;
          err_d        = 1'b1;
          state_d      = IDLE;
        end else begin
          case (state)
            DST: begin
              if (idx == 8'(ADDR_BYTES - 1)) begin
                idx_clr = 1'b1;
                if (addr_match) begin
                  state_d = SRC;
                end else begin
                  state_d  = DROP;
                  drop_inc = 1'b1;
                end
              end else begin
                idx_inc = 1'b1;
              end
            end
            SRC: begin
              if (idx == 8'(ADDR_BYTES - 1)) begin
                idx_clr = 1'b1;
                state_d = LEN;
              end else begin
                idx_inc = 1'b1;
              end
            end
            LEN: begin
              len_ld  = 1'b1;
              sum_clr = 1'b1;
              idx_clr = 1'b1;
              if (rx_data == 8'h00) begin
                state_d = CHK;
              end else if ({2'b00, rx_data} > free_space) begin
                state_d  = DROP;
                drop_inc = 1'b1;
              end else begin
                state_d = PAYLOAD;
              end
            end
            PAYLOAD: begin
              buf_wr  = 1'b1;
              idx_inc = 1'b1;
              if (idx == len - 8'd1) state_d = CHK;
            end
            CHK: begin
              state_d = IDLE;
              if (rx_data == sum) begin
                buf_commit = 1'b1;
                ok_d       = 1'b1;
              end else begin
                buf_rollback = 1'b1;
                err_d        = 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      idx       <= '0;
      len       <= '0;
      sum       <= '0;
      dst_sr    <= '0;
      last_len  <= '0;
      drop_cnt  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (pre_clr)
        pre_cnt <= '0;
      else if (pre_inc && pre_cnt != 8'hFF)
        pre_cnt <= pre_cnt + 8'd1;
      if (idx_clr)
        idx <= '0;
      else if (idx_inc)
        idx <= idx + 8'd1;
      if (state == DST && rx_valid)
        dst_sr <= {dst_sr[31:0], rx_data};
      if (len_ld)
        len <= rx_data;
      if (sum_clr)
        sum <= '0;
      else if (buf_wr)
        sum <= sum + rx_data;
      if (buf_commit)
        last_len <= len;
      if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      frame_ok  <= ok_d;
      frame_err <= err_d;
    end
  end

  rx_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_data  (rx_data),
    .commit   (buf_commit),
    .rollback (buf_rollback),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_count (rd_count)
  );

endmodule

// File: tb/tb_eth_frame_rx.sv
// Self-checking bench for eth_frame_rx: directed scenarios plus randomized
// frames checked against a queue-based model of the committed byte stream.
module tb_eth_frame_rx;
  import eth_pkg::*;

  localparam logic [47:0] MAC   = 48'h4A6F8A7FAA8F;
  localparam logic [47:0] OTHER = 48'h112233445566;
  localparam int          DEPTH = 16;

  typedef enum {R_OK, R_ERR, R_DROP} res_t;

  logic       clk = 1'b0;
  logic       rst, rx_valid, promisc, rd_en;
  logic [7:0] rx_data, rd_data, last_len, drop_cnt;
  logic [4:0] rd_count;
  logic       frame_ok, frame_err;

  eth_frame_rx #(
    .MAC_ADDR  (MAC),
    .BUF_DEPTH (DEPTH),
    .MIN_PRE   (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .promisc   (promisc),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_count  (rd_count),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .last_len  (last_len),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ok_seen = 0, err_seen = 0, both_seen = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] pl[$];
  int         exp_drop = 0;
  logic [7:0] exp_last = 8'h00;

  always @(negedge clk) begin
    if (frame_ok)              ok_seen++;
    if (frame_err)             err_seen++;
    if (frame_ok && frame_err) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pl_sum();
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s);
  endfunction

  function automatic res_t model_frame(input logic [47:0] dst, input bit prom,
                                       input logic [7:0] chk);
    if (!(dst == MAC || dst == 48'hFFFF_FFFF_FFFF || prom)) begin
      if (exp_drop < 255) exp_drop++;
      return R_DROP;
    end
    if (pl.size() != 0 && pl.size() > DEPTH - mq.size()) begin
      if (exp_drop < 255) exp_drop++;
      return R_DROP;
    end
    if (chk != pl_sum()) return R_ERR;
    foreach (pl[i]) mq.push_back(pl[i]);
    exp_last = 8'(pl.size());
    return R_OK;
  endfunction

  function automatic void fill_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction

  // cut >= 0 stops after that many payload bytes (gap, or reset if cut_rst).
  task automatic send_frame(input int pre_n, input logic [47:0] dst, input logic [7:0] len,
                            input logic [7:0] chk, input int cut = -1,
                            input bit cut_rst = 1'b0, input bit rd_on_chk = 1'b0);
    logic [7:0] q[$];
    int hdr;
    for (int i = 0; i < pre_n; i++) q.push_back(PRE_BYTE);
    q.push_back(SFD_BYTE);
    for (int i = 5; i >= 0; i--) q.push_back(dst[i*8 +: 8]);
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    q.push_back(len);
    hdr = q.size();
    foreach (pl[i]) q.push_back(pl[i]);
    q.push_back(chk);
    for (int i = 0; i < q.size(); i++) begin
      if (cut >= 0 && i == hdr + cut) begin
        rx_valid = 1'b0;
        if (cut_rst) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
        end
        break;
      end
      rx_valid = 1'b1;
      rx_data  = q[i];
      rd_en    = rd_on_chk && (i == q.size() - 1);
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd_en    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_read_back(input int n);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = mq.pop_front();
      n_cmp++;
      if (rd_data !== exp) begin
        n_bad++;
        $display("FAIL read_data[%0d]: got %02h expected %02h", i, rd_data, exp);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    n_cmp++;
    if (rd_count !== 5'(mq.size())) begin
      n_bad++;
      $display("FAIL read_count_after_drain: got %0d expected %0d", rd_count, mq.size());
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rd_count !== 5'd0 || rd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_buffer: rd_count %0d rd_data %02h expected 0/00", rd_count, rd_data);
    end
    n_cmp++;
    if ({frame_ok, frame_err} !== 2'b00 || drop_cnt !== 8'h00 || last_len !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_status: ok %b err %b drop %0d last %0d expected all zero",
               frame_ok, frame_err, drop_cnt, last_len);
    end
  endtask

  task automatic test_good_frame();
    int ok0 = ok_seen, err0 = err_seen;
    res_t r;
    pl = '{8'h01, 8'h02, 8'h03};
    r = model_frame(MAC, 1'b0, 8'h06);
    send_frame(7, MAC, 8'd3, 8'h06);
    n_cmp++;
    if (ok_seen - ok0 !== 1 || err_seen - err0 !== 0 || r != R_OK) begin
      n_bad++;
      $display("FAIL good_pulses: ok %0d err %0d expected 1/0", ok_seen - ok0, err_seen - err0);
    end
    n_cmp++;
    if (rd_count !== 5'd3 || last_len !== 8'd3) begin
      n_bad++;
      $display("FAIL good_counts: rd_count %0d last_len %0d expected 3/3", rd_count, last_len);
    end
    test_read_back(3);
  endtask

  task automatic test_bad_chk();
    int ok0 = ok_seen, err0 = err_seen;
    res_t r;
    pl = '{8'h01, 8'h02, 8'h03};
    r = model_frame(MAC, 1'b0, 8'h07);
    send_frame(7, MAC, 8'd3, 8'h07);
    n_cmp++;
    if (ok_seen - ok0 !== 0 || err_seen - err0 !== 1 || r != R_ERR) begin
      n_bad++;
      $display("FAIL badchk_pulses: ok %0d err %0d expected 0/1", ok_seen - ok0, err_seen - err0);
    end
    n_cmp++;
    if (rd_count !== 5'd0) begin
      n_bad++;
      $display("FAIL badchk_count: rd_count %0d expected 0", rd_count);
    end
    pl = '{8'hA1, 8'hB2, 8'hC3};
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd3, pl_sum());
    test_read_back(3);
  endtask

  task automatic test_addr_filter();
    int ok0 = ok_seen, err0 = err_seen;
    res_t r;
    fill_pl(3);
    promisc = 1'b0;
    r = model_frame(OTHER, 1'b0, pl_sum());
    send_frame(7, OTHER, 8'd3, pl_sum());
    n_cmp++;
    if (drop_cnt !== 8'd1 || ok_seen - ok0 !== 0 || err_seen - err0 !== 0 || rd_count !== 5'd0) begin
      n_bad++;
      $display("FAIL addr_mismatch: drop %0d ok %0d err %0d rd_count %0d expected 1/0/0/0",
               drop_cnt, ok_seen - ok0, err_seen - err0, rd_count);
    end
    promisc = 1'b1;
    r = model_frame(OTHER, 1'b1, pl_sum());
    send_frame(7, OTHER, 8'd3, pl_sum());
    n_cmp++;
    if (ok_seen - ok0 !== 1 || rd_count !== 5'd3) begin
      n_bad++;
      $display("FAIL addr_promisc: ok %0d rd_count %0d expected 1/3", ok_seen - ok0, rd_count);
    end
    promisc = 1'b0;
    fill_pl(3);
    r = model_frame(48'hFFFF_FFFF_FFFF, 1'b0, pl_sum());
    send_frame(7, 48'hFFFF_FFFF_FFFF, 8'd3, pl_sum());
    n_cmp++;
    if (ok_seen - ok0 !== 2 || rd_count !== 5'd6 || drop_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL addr_bcast: ok %0d rd_count %0d drop %0d expected 2/6/1",
               ok_seen - ok0, rd_count, drop_cnt);
    end
    test_read_back(6);
  endtask

  task automatic test_overflow_wrap();
    int ok0;
    res_t r;
    fill_pl(10);
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd10, pl_sum());
    ok0 = ok_seen;
    fill_pl(7);
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd7, pl_sum());
    n_cmp++;
    if (rd_count !== 5'd10 || drop_cnt !== 8'd2 || ok_seen !== ok0 || r != R_DROP) begin
      n_bad++;
      $display("FAIL overflow_drop: rd_count %0d drop %0d expected 10/2", rd_count, drop_cnt);
    end
    fill_pl(6);
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd6, pl_sum());
    n_cmp++;
    if (rd_count !== 5'd16 || ok_seen - ok0 !== 1 || last_len !== 8'd6) begin
      n_bad++;
      $display("FAIL overflow_full: rd_count %0d ok %0d last %0d expected 16/1/6",
               rd_count, ok_seen - ok0, last_len);
    end
    test_read_back(16);
  endtask

  task automatic test_abort();
    int ok0 = ok_seen, err0 = err_seen;
    res_t r;
    pl = '{8'h11, 8'h22};
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd2, pl_sum());
    fill_pl(4);
    send_frame(7, MAC, 8'd4, pl_sum(), 2);
    n_cmp++;
    if (err_seen - err0 !== 1 || ok_seen - ok0 !== 1 || rd_count !== 5'd2) begin
      n_bad++;
      $display("FAIL abort_payload: err %0d ok %0d rd_count %0d expected 1/1/2",
               err_seen - err0, ok_seen - ok0, rd_count);
    end
    ok0 = ok_seen; err0 = err_seen;
    fill_pl(2);
    send_frame(6, MAC, 8'd2, pl_sum());
    n_cmp++;
    if (ok_seen !== ok0 || err_seen !== err0 || rd_count !== 5'd2 || drop_cnt !== 8'(exp_drop)) begin
      n_bad++;
      $display("FAIL short_preamble: ok %0d err %0d rd_count %0d drop %0d expected 0/0/2/%0d",
               ok_seen - ok0, err_seen - err0, rd_count, drop_cnt, exp_drop);
    end
  endtask

  task automatic test_rd_during_commit();
    res_t r;
    logic [7:0] head;
    fill_pl(3);
    head = mq.pop_front();
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(8, MAC, 8'd3, pl_sum(), -1, 1'b0, 1'b1);
    n_cmp++;
    if (rd_count !== 5'd4 || r != R_OK) begin
      n_bad++;
      $display("FAIL rd_with_commit: rd_count %0d expected 4 (popped %02h)", rd_count, head);
    end
    test_read_back(4);
  endtask

  task automatic test_reset_mid();
    int ok0, err0;
    res_t r;
    fill_pl(5);
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd5, pl_sum());
    ok0 = ok_seen; err0 = err_seen;
    fill_pl(6);
    send_frame(7, MAC, 8'd6, pl_sum(), 3, 1'b1);
    mq.delete();
    exp_drop = 0;
    exp_last = 8'h00;
    n_cmp++;
    if (rd_count !== 5'd0 || drop_cnt !== 8'd0 || last_len !== 8'd0 || rd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_state: rd_count %0d drop %0d last %0d rd_data %02h expected zeros",
               rd_count, drop_cnt, last_len, rd_data);
    end
    n_cmp++;
    if (ok_seen !== ok0 || err_seen !== err0) begin
      n_bad++;
      $display("FAIL reset_mid_pulse: ok %0d err %0d expected 0/0", ok_seen - ok0, err_seen - err0);
    end
    fill_pl(4);
    r = model_frame(MAC, 1'b0, pl_sum());
    send_frame(7, MAC, 8'd4, pl_sum());
    n_cmp++;
    if (ok_seen - ok0 !== 1 || rd_count !== 5'd4 || last_len !== 8'd4) begin
      n_bad++;
      $display("FAIL reset_mid_recover: ok %0d rd_count %0d last %0d expected 1/4/4",
               ok_seen - ok0, rd_count, last_len);
    end
    test_read_back(4);
  endtask

  task automatic test_random();
    logic [47:0] dst;
    logic [7:0]  chk;
    bit          prom;
    res_t        r;
    int          ok0, err0, k;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       dst = MAC;
        1:       dst = 48'hFFFF_FFFF_FFFF;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      prom = ($urandom_range(0, 3) == 0);
      fill_pl($urandom_range(0, 8));
      chk = pl_sum();
      if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
      promisc = prom;
      ok0 = ok_seen; err0 = err_seen;
      r = model_frame(dst, prom, chk);
      send_frame($urandom_range(7, 10), dst, 8'(pl.size()), chk);
      n_cmp++;
      if (ok_seen - ok0 !== int'(r == R_OK) || err_seen - err0 !== int'(r == R_ERR)) begin
        n_bad++;
        $display("FAIL rand_pulses[%0d]: ok %0d err %0d expected %0d/%0d", it,
                 ok_seen - ok0, err_seen - err0, int'(r == R_OK), int'(r == R_ERR));
      end
      n_cmp++;
      if (rd_count !== 5'(mq.size()) || drop_cnt !== 8'(exp_drop) || last_len !== exp_last) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: rd_count %0d drop %0d last %0d expected %0d/%0d/%0d", it,
                 rd_count, drop_cnt, last_len, mq.size(), exp_drop, exp_last);
      end
      k = $urandom_range(0, mq.size());
      test_read_back(k);
    end
    promisc = 1'b0;
    n_cmp++;
    if (both_seen !== 0) begin
      n_bad++;
      $display("FAIL ok_err_overlap: got %0d cycles expected 0", both_seen);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    promisc  = 1'b0;
    rd_en    = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_good_frame();
    test_bad_chk();
    test_addr_filter();
    test_overflow_wrap();
    test_abort();
    test_rd_during_commit();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_rx.md
ETH_FRAME_RX -- requirements
Module: eth_frame_rx

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h4A6F8A7FAA8F, station address matched against destination field.
REQ-002 SHALL have parameter BUF_DEPTH, default 16, payload buffer depth in bytes; power of two, 4..256.
REQ-003 SHALL have parameter MIN_PRE, default 7, minimum consecutive 0x55 bytes before SFD.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_valid  input  1  rx_data holds a frame byte this cycle.
REQ-007 rx_data  input  8  received byte stream.
REQ-008 promisc  input  1  accept any destination address.
REQ-009 rd_en  input  1  pop one committed payload byte.
REQ-010 rd_data  output  8  head committed byte (first-word-fall-through).
REQ-011 rd_count  output  $clog2(BUF_DEPTH)+1  committed bytes available.
REQ-012 frame_ok  output  1  one-cycle pulse: frame accepted and committed.
REQ-013 frame_err  output  1  one-cycle pulse: checksum mismatch or truncation.
REQ-014 last_len  output  8  payload length of last accepted frame.
REQ-015 drop_cnt  output  8  frames dropped for overflow or address mismatch, saturating at 255.

Function
REQ-016 Frame format SHALL be: >=MIN_PRE x 0x55, 0xD5 SFD, 6-byte destination (MSB first), 6-byte source, 1-byte length L, L payload bytes, 1-byte checksum = sum of payload bytes mod 256.
REQ-017 FSM states SHALL be IDLE, DST, SRC, LEN, PAYLOAD, CHK, DROP; only bytes with rx_valid=1 advance the FSM.
REQ-018 IDLE: 0x55 increments preamble count (saturating); 0xD5 with count>=MIN_PRE -> DST; any other byte or short-preamble SFD clears count and stays IDLE.
REQ-019 DST: after 6th byte, match if equal to MAC_ADDR, or 48'hFFFFFFFFFFFF, or promisc=1 -> SRC; else -> DROP, drop_cnt+1.
REQ-020 SRC: consume 6 bytes -> LEN.
REQ-021 LEN: L=0 -> CHK; L > BUF_DEPTH - rd_count (free committed space) -> DROP, drop_cnt+1; else -> PAYLOAD, running sum cleared.
REQ-022 PAYLOAD: each byte written at speculative write pointer and added to sum; after L bytes -> CHK.
REQ-023 CHK: byte equal to sum -> commit pointer := write pointer, last_len := L, frame_ok pulse next cycle; else rollback write pointer to commit pointer, frame_err pulse; both -> IDLE.
REQ-024 rx_valid=0 in DST, SRC, LEN, PAYLOAD or CHK SHALL abort: rollback, frame_err pulse, -> IDLE.
REQ-025 DROP SHALL ignore bytes and return to IDLE on first cycle with rx_valid=0.
REQ-026 Uncommitted bytes SHALL never be visible on rd_data or counted in rd_count.
REQ-027 rd_en with rd_count=0 SHALL be ignored; otherwise read pointer advances and rd_count decrements the next cycle.
REQ-028 Simultaneous rd_en and commit SHALL yield rd_count = old + L - 1.
REQ-029 Pointers SHALL wrap modulo BUF_DEPTH; a frame with L = free space exactly SHALL be accepted (buffer full).
REQ-030 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-031 rst SHALL force IDLE, clear all pointers, preamble count, sum, drop_cnt, last_len, frame_ok, frame_err; rd_count=0, rd_data=0.
REQ-032 rst mid-frame SHALL discard both speculative and committed data; no pulse emitted.

Structure
REQ-033 Package eth_pkg SHALL hold the state enumeration, constants PRE_BYTE=8'h55, SFD_BYTE=8'hD5, BCAST_MAC=48'hFFFFFFFFFFFF.
REQ-034 Sub-module rx_buffer SHALL implement the circular buffer with write, commit, rollback and read ports; eth_frame_rx holds FSM, address compare, checksum.

Verification
REQ-035 7x55, D5, DST=4A6F8A7FAA8F, any SRC, L=3, 01 02 03, chk 06 -> frame_ok, rd_count=3, last_len=3, reads 01,02,03.
REQ-036 Same frame, chk 07 -> frame_err, rd_count stays 0, next good frame reads from original pointer.
REQ-037 DST=112233445566, promisc=0 -> drop_cnt=1, no pulse; repeat with promisc=1 -> frame_ok; DST=FFFFFFFFFFFF, promisc=0 -> frame_ok.
REQ-038 BUF_DEPTH=16, rd_count=10, L=7 -> drop_cnt+1, rd_count=10; L=6 -> accepted, rd_count=16, pointers wrap correctly.
REQ-039 rx_valid dropped after 2nd payload byte -> frame_err, rd_count unchanged; 6x55 then D5 -> stays IDLE, no pulse.
REQ-040 rst asserted during PAYLOAD with rd_count=5 -> rd_count=0, drop_cnt=0, next valid frame accepted normally.
